// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - issue stage driving a 32-bit ALU, 64-bit add/sub in two carry-chained passes
//
// Ports:
//   clk, reset_n                     clock, asynchronous active-low reset
//   cmd_valid/cmd_ready              command handshake; cmd_op, cmd_a, cmd_b payload
//   alu_in1/alu_in2/alu_binvert/
//   alu_cin/alu_operation            ALU control and operands (all 0 outside LO/HI)
//   alu_result/alu_carry             combinational ALU result and carry-out
//   rsp_valid/rsp_ready              response handshake
//   rsp_data, rsp_carry, rsp_zero,
//   rsp_neg                          registered result and flags
//   rsp_ovf                          signed overflow flag, only when ALU_SEQ_OVF_EN is defined
module alu_op_sequencer (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_op,
    input  logic [63:0] cmd_a,
    input  logic [63:0] cmd_b,
    output logic [31:0] alu_in1,
    output logic [31:0] alu_in2,
    output logic        alu_binvert,
    output logic        alu_cin,
    output logic [1:0]  alu_operation,
    input  logic [31:0] alu_result,
    input  logic        alu_carry,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_data,
    output logic        rsp_carry,
    output logic        rsp_zero,
    output logic        rsp_neg
`ifdef ALU_SEQ_OVF_EN
    ,
    output logic        rsp_ovf
`endif
);

    localparam logic [2:0] OP_AND32 = 3'b000;
    localparam logic [2:0] OP_OR32  = 3'b001;
    localparam logic [2:0] OP_ADD32 = 3'b010;
    localparam logic [2:0] OP_SUB32 = 3'b011;
    localparam logic [2:0] OP_SLT32 = 3'b100;
    localparam logic [2:0] OP_ADD64 = 3'b101;
    localparam logic [2:0] OP_SUB64 = 3'b110;
    localparam logic [2:0] OP_CLR   = 3'b111;

    typedef enum logic [1:0] {IDLE, LO, HI, RESP} state_t;

    state_t      state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic [63:0] a_q, a_d, b_q, b_d;
    logic [63:0] data_q, data_d;
    logic        carry_q, carry_d;
    logic        rsp_carry_q, rsp_carry_d;
    logic        zero_q, zero_d;
    logic        neg_q, neg_d;

    logic        is_sub;
    logic        y_msb;
    logic        ovf_w;

    assign is_sub = (op_q == OP_SUB32) || (op_q == OP_SLT32) || (op_q == OP_SUB64);

    // Overflow of the pass currently on the ALU, taken from its bit 31.
    assign y_msb = alu_binvert ? ~alu_in2[31] : alu_in2[31];
    assign ovf_w = (alu_in1[31] == y_msb) && (alu_result[31] != alu_in1[31]);

    assign cmd_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_data  = data_q;
    assign rsp_carry = rsp_carry_q;
    assign rsp_zero  = zero_q;
    assign rsp_neg   = neg_q;

    always_comb begin
        alu_in1       = 32'd0;
        alu_in2       = 32'd0;
        alu_binvert   = 1'b0;
        alu_cin       = 1'b0;
        alu_operation = 2'b00;
        case (state_q)
            LO: begin
                if (op_q != OP_CLR) begin
                    alu_in1     = a_q[31:0];
                    alu_in2     = b_q[31:0];
                    alu_binvert = is_sub;
                    alu_cin     = is_sub;
                    case (op_q)
                        OP_AND32: alu_operation = 2'b00;
                        OP_OR32:  alu_operation = 2'b01;
                        default:  alu_operation = 2'b10;
                    endcase
                end
            end
            HI: begin
                alu_in1       = a_q[63:32];
                alu_in2       = b_q[63:32];
                alu_binvert   = is_sub;
                alu_cin       = carry_q;
                alu_operation = 2'b10;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        data_d      = data_q;
        carry_d     = carry_q;
        rsp_carry_d = rsp_carry_q;
        zero_d      = zero_q;
        neg_d       = neg_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    op_d    = cmd_op;
                    a_d     = cmd_a;
                    b_d     = cmd_b;
                    state_d = LO;
                end
            end
            LO: begin
                carry_d     = alu_carry;
                rsp_carry_d = 1'b0;
                state_d     = RESP;
                case (op_q)
                    OP_AND32, OP_OR32: data_d = {32'd0, alu_result};
                    OP_ADD32, OP_SUB32: begin
                        data_d      = {32'd0, alu_result};
                        rsp_carry_d = alu_carry;
                    end
                    OP_SLT32: data_d = {63'd0, alu_result[31] ^ ovf_w};
                    OP_ADD64, OP_SUB64: begin
                        data_d[31:0] = alu_result;
                        state_d      = HI;
                    end
                    default: data_d = 64'd0;
                endcase
                zero_d = (data_d == 64'd0);
                neg_d  = data_d[31];
            end
            HI: begin
                data_d[63:32] = alu_result;
                rsp_carry_d   = alu_carry;
                zero_d        = (data_d == 64'd0);
                neg_d         = alu_result[31];
                state_d       = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            op_q        <= 3'd0;
            a_q         <= 64'd0;
            b_q         <= 64'd0;
            data_q      <= 64'd0;
            carry_q     <= 1'b0;
            rsp_carry_q <= 1'b0;
            zero_q      <= 1'b0;
            neg_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            data_q      <= data_d;
            carry_q     <= carry_d;
            rsp_carry_q <= rsp_carry_d;
            zero_q      <= zero_d;
            neg_q       <= neg_d;
        end
    end

`ifdef ALU_SEQ_OVF_EN
    logic ovf_q;

    // The 64-bit LO pass clears the flag; the HI pass then supplies the real value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ovf_q <= 1'b0;
        end else if (state_q == LO) begin
            ovf_q <= ((op_q == OP_ADD32) || (op_q == OP_SUB32)) ? ovf_w : 1'b0;
        end else if (state_q == HI) begin
            ovf_q <= ovf_w;
        end
    end

    assign rsp_ovf = ovf_q;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - directed scoreboard bench for alu_op_sequencer
module tb_alu_op_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [63:0] cmd_a, cmd_b;
    logic [31:0] alu_in1, alu_in2;
    logic        alu_binvert, alu_cin;
    logic [1:0]  alu_operation;
    logic [31:0] alu_result;
    logic        alu_carry;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_data;
    logic        rsp_carry, rsp_zero, rsp_neg;
`ifdef ALU_SEQ_OVF_EN
    logic        rsp_ovf;
`endif

    int tests  = 0;
    int failed = 0;
    logic last_cin;

    typedef struct packed {
        logic [63:0] data;
        logic        carry;
        logic        zero;
        logic        neg;
        logic        ovf;
    } rsp_t;

    rsp_t exp_q[$];

    always #5 clk = ~clk;

    alu_op_sequencer dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_op        (cmd_op),
        .cmd_a         (cmd_a),
        .cmd_b         (cmd_b),
        .alu_in1       (alu_in1),
        .alu_in2       (alu_in2),
        .alu_binvert   (alu_binvert),
        .alu_cin       (alu_cin),
        .alu_operation (alu_operation),
        .alu_result    (alu_result),
        .alu_carry     (alu_carry),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_data      (rsp_data),
        .rsp_carry     (rsp_carry),
        .rsp_zero      (rsp_zero),
        .rsp_neg       (rsp_neg)
`ifdef ALU_SEQ_OVF_EN
        ,
        .rsp_ovf       (rsp_ovf)
`endif
    );

    // Behavioural 32-bit ALU
    logic [32:0] alu_sum;
    assign alu_sum = {1'b0, alu_in1} + {1'b0, (alu_binvert ? ~alu_in2 : alu_in2)} + {32'd0, alu_cin};
    always_comb begin
        alu_result = 32'd0;
        alu_carry  = 1'b0;
        case (alu_operation)
            2'b00: alu_result = alu_in1 & alu_in2;
            2'b01: alu_result = alu_in1 | alu_in2;
            default: begin
                alu_result = alu_sum[31:0];
                alu_carry  = alu_sum[32];
            end
        endcase
    end

    function automatic rsp_t model(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
        rsp_t r;
        logic [32:0] s32;
        logic [64:0] s64;
        r = '0;
        case (op)
            3'd0: r.data = {32'd0, a[31:0] & b[31:0]};
            3'd1: r.data = {32'd0, a[31:0] | b[31:0]};
            3'd2: begin
                s32 = {1'b0, a[31:0]} + {1'b0, b[31:0]};
                r.data = {32'd0, s32[31:0]}; r.carry = s32[32];
                r.ovf = (a[31] == b[31]) && (s32[31] != a[31]);
            end
            3'd3: begin
                s32 = {1'b0, a[31:0]} + {1'b0, ~b[31:0]} + 33'd1;
                r.data = {32'd0, s32[31:0]}; r.carry = s32[32];
                r.ovf = (a[31] != b[31]) && (s32[31] != a[31]);
            end
            3'd4: r.data = ($signed(a[31:0]) < $signed(b[31:0])) ? 64'd1 : 64'd0;
            3'd5: begin
                s64 = {1'b0, a} + {1'b0, b};
                r.data = s64[63:0]; r.carry = s64[64];
                r.ovf = (a[63] == b[63]) && (s64[63] != a[63]);
            end
            3'd6: begin
                s64 = {1'b0, a} + {1'b0, ~b} + 65'd1;
                r.data = s64[63:0]; r.carry = s64[64];
                r.ovf = (a[63] != b[63]) && (s64[63] != a[63]);
            end
            default: r.data = 64'd0;
        endcase
        r.zero = (r.data == 64'd0);
        r.neg  = (op == 3'd5 || op == 3'd6) ? r.data[63] : r.data[31];
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b, input bit push);
        logic ok;
        ok = 1'b0;
        cmd_op = op; cmd_a = a; cmd_b = b; cmd_valid = 1'b1;
        if (push) exp_q.push_back(model(op, a, b));
        for (int i = 0; i < 20 && !ok; i++) begin
            ok = cmd_ready;
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
        check("accept", {63'd0, ok}, 64'd1);
    endtask

    task automatic wait_rsp(input string tag, input int lat);
        int n;
        logic busy_ready;
        rsp_t r;
        n = 0;
        busy_ready = 1'b0;
        while (!rsp_valid && n < 10) begin
            last_cin = alu_cin;
            busy_ready |= cmd_ready;
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_latency"}, 64'(n), 64'(lat));
        check({tag, "_busy_ready"}, {63'd0, busy_ready}, 64'd0);
        if (exp_q.size() == 0) begin
            check({tag, "_queue_empty"}, 64'd0, 64'd1);
        end else begin
            r = exp_q.pop_front();
            check({tag, "_data"}, rsp_data, r.data);
            check({tag, "_carry"}, {63'd0, rsp_carry}, {63'd0, r.carry});
            check({tag, "_zero"}, {63'd0, rsp_zero}, {63'd0, r.zero});
            check({tag, "_neg"}, {63'd0, rsp_neg}, {63'd0, r.neg});
`ifdef ALU_SEQ_OVF_EN
            check({tag, "_ovf"}, {63'd0, rsp_ovf}, {63'd0, r.ovf});
`endif
        end
    endtask

    task automatic release_rsp(input string tag);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check({tag, "_valid_drop"}, {63'd0, rsp_valid}, 64'd0);
        check({tag, "_ready_back"}, {63'd0, cmd_ready}, 64'd1);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_rsp_valid"}, {63'd0, rsp_valid}, 64'd0);
        check({tag, "_alu_ops"}, {alu_in1, alu_in2}, 64'd0);
        check({tag, "_alu_ctl"}, {60'd0, alu_binvert, alu_cin, alu_operation}, 64'd0);
        check({tag, "_cmd_ready"}, {63'd0, cmd_ready}, 64'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; cmd_valid = 1'b1; cmd_op = 3'd2; cmd_a = 64'd3; cmd_b = 64'd4;
        rsp_ready = 1'b0; last_cin = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        // A command presented during reset must not be taken.
        check_idle_outputs("reset");
        check("reset_data", rsp_data, 64'd0);
        check("reset_flags", {61'd0, rsp_carry, rsp_zero, rsp_neg}, 64'd0);
        cmd_valid = 1'b0;
        reset_n = 1'b1;
        @(posedge clk); #1;

        send(3'd5, 64'h0000_0000_FFFF_FFFF, 64'd1, 1'b1);
        wait_rsp("add64", 2);
        check("add64_hi_cin", {63'd0, last_cin}, 64'd1);
        release_rsp("add64");

        send(3'd3, 64'd5, 64'd7, 1'b1);
        wait_rsp("sub32", 1);
        release_rsp("sub32");

        send(3'd4, 64'h8000_0000, 64'd1, 1'b1);
        wait_rsp("slt32", 1);
        release_rsp("slt32");

        send(3'd2, 64'h7FFF_FFFF, 64'd1, 1'b1);
        wait_rsp("add32_ovf", 1);
        release_rsp("add32_ovf");

        // Backpressure with a second command waiting behind the response.
        send(3'd0, 64'hF0F0, 64'hFF00, 1'b1);
        wait_rsp("and32", 1);
        cmd_op = 3'd1; cmd_a = 64'h1234_0000; cmd_b = 64'h0000_5678; cmd_valid = 1'b1;
        exp_q.push_back(model(3'd1, 64'h1234_0000, 64'h0000_5678));
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp_data", rsp_data, 64'hF000);
            check("bp_hold", {62'd0, rsp_valid, cmd_ready}, 64'd2);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("bp_not_yet_taken", {63'd0, cmd_ready}, 64'd1);
        @(posedge clk); #1;
        check("bp_taken_next", {63'd0, cmd_ready}, 64'd0);
        cmd_valid = 1'b0;
        wait_rsp("or32", 1);
        release_rsp("or32");

        send(3'd7, 64'hDEAD_BEEF_0000_0001, 64'd9, 1'b1);
        wait_rsp("clr", 1);
        release_rsp("clr");

        send(3'd6, 64'd0, 64'd1, 1'b1);
        wait_rsp("sub64", 2);
        release_rsp("sub64");

        for (int k = 0; k < 6; k++) begin
            logic [2:0]  op;
            logic [63:0] a, b;
            op = 3'($urandom_range(0, 7));
            a  = {$urandom(), $urandom()};
            b  = {$urandom(), $urandom()};
            send(op, a, b, 1'b1);
            wait_rsp("rand", (op == 3'd5 || op == 3'd6) ? 2 : 1);
            release_rsp("rand");
        end

        // Reset asserted during the HI pass of an ADD64.
        send(3'd5, 64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0);
        @(posedge clk); #1;
        check("midop_hi_cin", {63'd0, alu_cin}, 64'd1);
        reset_n = 1'b0;
        #1;
        check_idle_outputs("midop_reset");
        check("midop_data", rsp_data, 64'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        check("midop_after_ready", {63'd0, cmd_ready}, 64'd1);
        check("midop_after_valid", {63'd0, rsp_valid}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
